mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the ALU result as the effective address and register read data 2 as store data.
- Runs loads and stores over a simple req/ready data-memory port, then returns the extended load data to write-back.
- Multi-cycle: a small FSM, a timeout counter, and alignment and illegal-op checks.

Parameters:
- WORD_BITWIDTH, 32, data and address width.
- TIMEOUT_CYCLES, 16, maximum number of cycles mem_req is held before the access is abandoned (≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; launch the operation.
- MemRead  input  1  load request, sampled with start.
- MemWrite  input  1  store request, sampled with start.
- funct3  input  3  access size/sign, sampled with start.
- ALUresult  input  WORD_BITWIDTH  effective byte address.
- regReadData2  input  WORD_BITWIDTH  store data.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle completion pulse.
- readData  output  WORD_BITWIDTH  extended load result; held until next accepted start.
- misaligned  output  1  valid with done only.
- bus_error  output  1  valid with done only; timeout or illegal op.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  WORD_BITWIDTH  word-aligned address {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  WORD_BITWIDTH  lane-replicated store data.
- mem_ready  input  1  memory accepts/completes in this cycle.
- mem_rdata  input  WORD_BITWIDTH  read word, valid when mem_ready=1.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: state IDLE, counter 0, all outputs 0 (readData=0).
- Reset mid-access drops mem_req at that edge; no done is produced.
- States:
  - IDLE: start accepted only here; start while busy is ignored.
  - ACCESS: mem_req=1.
  - FINISH: done=1 for one cycle, then IDLE.
- Decode on start in IDLE (outputs registered, so results appear next cycle):
  - MemRead=MemWrite=0: go to FINISH; readData=0, flags 0.
  - MemRead=MemWrite=1: go to FINISH with bus_error=1; no bus access.
  - Illegal funct3 → FINISH with bus_error=1. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal. Legal stores: 000 SB, 001 SH, 010 SW; others illegal.
  - Misaligned → FINISH with misaligned=1, bus_error=0, no mem_req. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise latch address, funct3, data and direction, then enter ACCESS.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until exit.
  - mem_be on loads: 4'b1111.
  - mem_be on stores: SB = 4'b0001<<addr[1:0]; SH = addr[1] ? 4'b1100 : 4'b0011; SW = 4'b1111.
  - mem_wdata: SB = byte replicated ×4; SH = half replicated ×2; SW = word.
  - mem_ready=1: deassert mem_req at the next edge and enter FINISH.
    - On loads, readData captures the extracted data at that same edge.
    - Byte lane = addr[1:0]; half lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Timeout:
    - The counter clears on ACCESS entry and increments each ACCESS cycle with mem_ready=0.
    - If counter==TIMEOUT_CYCLES-1 and mem_ready=0, go to FINISH with bus_error=1 and readData=0.
    - mem_req is therefore high for at most TIMEOUT_CYCLES cycles.
    - mem_ready=1 in that last cycle completes normally.
- Latency:
  - start at cycle T; mem_req high from T+1.
  - mem_ready at T+k gives done at T+k+1.
  - Best case: done at T+2.
  - No-access cases: done at T+2.
- mem_ready outside ACCESS is ignored. done is never high in two consecutive cycles.

Test Plan:
- LB sign extension:
  - Stimulus: load at 0x103, funct3=000, mem_rdata=0x80FF_1234, ready in first ACCESS cycle.
  - Required: mem_addr=0x100, mem_be=1111, done at T+2, readData=0xFFFF_FF80.
- LHU:
  - Stimulus: same load with funct3=101 at 0x102.
  - Required: readData=0x0000_80FF.
- SH:
  - Stimulus: store to 0x1002, regReadData2=0xDEAD_BEEF, funct3=001.
  - Required: mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x1000.
- Misaligned LW:
  - Stimulus: LW at 0x2001.
  - Required: mem_req never asserted; done at T+2 with misaligned=1, bus_error=0.
- Timeout:
  - Stimulus: mem_ready held 0 with TIMEOUT_CYCLES=16.
  - Required: mem_req high exactly 16 cycles; done with bus_error=1, readData=0.
  - Repeat with mem_ready=1 on the 16th cycle: normal completion.
- Reset and start while busy:
  - Stimulus: rst=1 on the 3rd ACCESS cycle.
  - Required: mem_req=0, busy=0 after that edge, no done.
  - Stimulus: start pulsed during ACCESS.
  - Required: ignored; exactly one done.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Decodes one load/store request per start pulse,
// runs it over a req/ready data-memory port with a timeout, and returns the
// size/sign-extended load data along with alignment and bus-error flags.
// Handshake: mem_req is high for the whole ACCESS state, and the request fields
// stay stable until exit. The transfer happens in the first ACCESS cycle that
// has mem_ready=1. mem_ready outside ACCESS has no effect.
module mem_access_stage #(
    parameter int WORD_BITWIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               funct3,
    input  logic [WORD_BITWIDTH-1:0] ALUresult,
    input  logic [WORD_BITWIDTH-1:0] regReadData2,
    output logic                     busy,
    output logic                     done,
    output logic [WORD_BITWIDTH-1:0] readData,
    output logic                     misaligned,
    output logic                     bus_error,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WORD_BITWIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [WORD_BITWIDTH-1:0] mem_wdata,
    input  logic                     mem_ready,
    input  logic [WORD_BITWIDTH-1:0] mem_rdata,
    output logic [1:0]               dbg_state
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    // S_SKIP is a one-cycle hold so that requests needing no bus access
    // complete with the same start-to-done latency as the fastest access.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SKIP   = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                   r_state, w_next;
    logic [CW-1:0]            r_cnt;
    logic                     r_we;
    logic [WORD_BITWIDTH-1:0] r_addr;
    logic [1:0]               r_off;
    logic [2:0]               r_f3;
    logic [3:0]               r_be;
    logic [WORD_BITWIDTH-1:0] r_wdata;
    logic [WORD_BITWIDTH-1:0] r_readData;
    logic                     r_misaligned;
    logic                     r_bus_error;

    logic                     w_accept, w_none, w_both, w_legal, w_misal;
    logic                     w_err, w_mis_only, w_go_access, w_timeout;
    logic [3:0]               w_be;
    logic [WORD_BITWIDTH-1:0] w_wdata, w_load;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;

    // Request decode, evaluated with start
    assign w_accept    = start && (r_state == S_IDLE);
    assign w_none      = !MemRead && !MemWrite;
    assign w_both      = MemRead && MemWrite;
    assign w_legal     = MemRead ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                 : (funct3 inside {3'b000, 3'b001, 3'b010});
    assign w_misal     = ((funct3[1:0] == 2'b01) && ALUresult[0]) ||
                         ((funct3[1:0] == 2'b10) && (ALUresult[1:0] != 2'b00));
    assign w_err       = w_both || (!w_none && !w_legal);
    assign w_mis_only  = !w_none && !w_err && w_misal;
    assign w_go_access = !w_none && !w_err && !w_misal;
    assign w_timeout   = (r_cnt == LAST) && !mem_ready;

    // Store byte enables and lane-replicated write data; loads read the full word
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = regReadData2;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ALUresult[1:0];
                    w_wdata = {(WORD_BITWIDTH/8){regReadData2[7:0]}};
                end
                2'b01: begin
                    w_be    = ALUresult[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {(WORD_BITWIDTH/16){regReadData2[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load lane extraction and sign/zero extension from the returned word
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load = {{(WORD_BITWIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(WORD_BITWIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(WORD_BITWIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(WORD_BITWIDTH-16){1'b0}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_go_access ? S_ACCESS : S_SKIP;
            S_SKIP:   w_next = S_FINISH;
            S_ACCESS: if (mem_ready || w_timeout) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Request latch, timeout counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_off        <= 2'b00;
            r_f3         <= 3'b000;
            r_be         <= 4'b0000;
            r_wdata      <= '0;
            r_readData   <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else if (w_accept) begin
            r_readData   <= '0;
            r_misaligned <= w_mis_only;
            r_bus_error  <= w_err;
            r_cnt        <= '0;
            if (w_go_access) begin
                r_we    <= MemWrite;
                r_addr  <= {ALUresult[WORD_BITWIDTH-1:2], 2'b00};
                r_off   <= ALUresult[1:0];
                r_f3    <= funct3;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
        end else if (r_state == S_ACCESS) begin
            if (mem_ready) begin
                if (!r_we) r_readData <= w_load;
            end else if (r_cnt == LAST) begin
                r_bus_error <= 1'b1;
                r_readData  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign mem_req    = (r_state == S_ACCESS);
    assign mem_we     = mem_req && r_we;
    assign mem_addr   = mem_req ? r_addr : '0;
    assign mem_be     = mem_req ? r_be : 4'b0000;
    assign mem_wdata  = mem_req ? r_wdata : '0;
    assign readData   = r_readData;
    assign misaligned = done && r_misaligned;
    assign bus_error  = done && r_bus_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads with every extension, stores with
// lane enables, misaligned/illegal/no-op requests, timeout, reset mid-access
// and start while busy. Memory side is driven directly by the bench.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst, start, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUresult, regReadData2, readData, mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, misaligned, bus_error, mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    mem_access_stage #(.WORD_BITWIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUresult(ALUresult), .regReadData2(regReadData2),
        .busy(busy), .done(done), .readData(readData), .misaligned(misaligned),
        .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one operation and follow it to done. wait_n = number of ACCESS
    // cycles with mem_ready=0 before the ready cycle (>=16 means never ready).
    task automatic run_op(input string tag, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int wait_n, input logic exp_access,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_read, input logic exp_mis,
                          input logic exp_berr);
        int          req_n = 0;
        int          lat = 1;
        bit          seen = 0;
        int          exp_req;
        logic [31:0] exp_rd;
        exp_req = exp_access ? ((wait_n + 1 > 16) ? 16 : wait_n + 1) : 0;
        exp_q.push_back(exp_read);
        start = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3;
        ALUresult = addr; regReadData2 = wd; mem_rdata = rd; mem_ready = 1'b0;
        tick;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (mem_req) begin
                req_n++;
                check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
                check({tag, " be"}, {28'd0, mem_be}, {28'd0, exp_be});
                check({tag, " we"}, {31'd0, mem_we}, {31'd0, mw});
                if (mw) check({tag, " wdata"}, mem_wdata, exp_wdata);
            end
            mem_ready = mem_req && (req_n == wait_n + 1);
            tick;
            lat++;
        end
        mem_ready = 1'b0;
        exp_rd = exp_q.pop_front();
        check({tag, " done seen"}, {31'd0, seen}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_req == 0 ? 2 : exp_req + 1));
        check({tag, " req cycles"}, 32'(req_n), 32'(exp_req));
        check({tag, " readData"}, readData, exp_rd);
        check({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
        check({tag, " bus_error"}, {31'd0, bus_error}, {31'd0, exp_berr});
        tick;
        check({tag, " done 1 cycle"}, {31'd0, done}, 32'd0);
        check({tag, " idle after"}, {31'd0, busy}, 32'd0);
        check({tag, " readData held"}, readData, exp_rd);
    endtask

    initial begin
        int done_n;
        rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        ALUresult = '0; regReadData2 = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick; tick;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset readData", readData, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset mem_be", {28'd0, mem_be}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        tick;

        // loads
        run_op("LB",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 4'hF, 32'h0, 32'hFFFF_FF80, 0, 0);
        run_op("LHU", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 0, 1, 4'hF, 32'h0, 32'h0000_80FF, 0, 0);
        run_op("LH",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 1, 4'hF, 32'h0, 32'hFFFF_80FF, 0, 0);
        run_op("LBU", 1, 0, 3'b100, 32'h101, 32'h0, 32'h80FF_1234, 0, 1, 4'hF, 32'h0, 32'h0000_0012, 0, 0);
        run_op("LB0", 1, 0, 3'b000, 32'h100, 32'h0, 32'h80FF_1234, 0, 1, 4'hF, 32'h0, 32'h0000_0034, 0, 0);
        run_op("LW",  1, 0, 3'b010, 32'h104, 32'h0, 32'h80FF_1234, 3, 1, 4'hF, 32'h0, 32'h80FF_1234, 0, 0);
        // stores
        run_op("SH",  0, 1, 3'b001, 32'h1002, 32'hDEAD_BEEF, 32'h0, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 0);
        run_op("SB",  0, 1, 3'b000, 32'h1001, 32'hDEAD_BEEF, 32'h0, 0, 1, 4'b0010, 32'hEFEF_EFEF, 32'h0, 0, 0);
        run_op("SW",  0, 1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 0);
        // no-access outcomes
        run_op("misLW", 1, 0, 3'b010, 32'h2001, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        run_op("misLW2",1, 0, 3'b010, 32'h2002, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        run_op("misSH", 0, 1, 3'b001, 32'h2003, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        run_op("noop",  0, 0, 3'b010, 32'h2001, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        run_op("both",  1, 1, 3'b010, 32'h3000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        run_op("illLd", 1, 0, 3'b011, 32'h3000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        run_op("illSt", 0, 1, 3'b100, 32'h3000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        // timeout and last-cycle completion
        run_op("tmo",   1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 99, 1, 4'hF, 32'h0, 32'h0, 0, 1);
        run_op("last",  1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 15, 1, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 0);

        // reset on the 3rd ACCESS cycle
        start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        ALUresult = 32'h400; mem_ready = 1'b0;
        tick;
        start = 1'b0;
        tick; tick;
        check("rst pre mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst readData", readData, 32'd0);
        done_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_n++;
            tick;
        end
        check("rst no done", 32'(done_n), 32'd0);

        // start while busy is ignored
        start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        ALUresult = 32'h600; mem_rdata = 32'h1122_3344;
        tick;
        start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; ALUresult = 32'h700;
        tick;
        start = 1'b0;
        check("busy-start we", {31'd0, mem_we}, 32'd0);
        check("busy-start addr", mem_addr, 32'h600);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_n++;
            tick;
        end
        check("busy-start one done", 32'(done_n), 32'd1);
        check("busy-start readData", readData, 32'h1122_3344);
        check("busy-start idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
